// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch predictor / resolver: condition-code
// encodings and the reset value of the BHT saturating counters.
package branch_predict_resolve_pkg;

  localparam logic [2:0] COND_EQZ    = 3'd0;
  localparam logic [2:0] COND_NEZ    = 3'd1;
  localparam logic [2:0] COND_LTZ    = 3'd2;
  localparam logic [2:0] COND_GEZ    = 3'd3;
  localparam logic [2:0] COND_GTZ    = 3'd4;
  localparam logic [2:0] COND_LEZ    = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  // Weakly-not-taken counter value: one below the taken threshold.
  function automatic int weak_nt_init(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_cond_eval.sv
// Combinational branch condition evaluator: signed operand tested against
// zero according to a 3-bit condition code. NEVER resolves not-taken.
module branch_cond_eval #(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        cond,
  input  logic [DATA_W-1:0] opnd,
  output logic              taken
);
  import branch_predict_resolve_pkg::*;

  logic is_zero;
  logic is_neg;

  assign is_zero = (opnd == '0);
  assign is_neg  = opnd[DATA_W-1];

  // Decode the condition code into a taken/not-taken outcome.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQZ:    taken = is_zero;
      COND_NEZ:    taken = ~is_zero;
      COND_LTZ:    taken = is_neg;
      COND_GEZ:    taken = ~is_neg;
      COND_GTZ:    taken = ~is_neg & ~is_zero;
      COND_LEZ:    taken = is_neg | is_zero;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch predictor and resolver: direct-mapped BHT of saturating counters
// read at fetch, trained at execute; registered mispredict flush/redirect
// and saturating branch statistics.
module branch_predict_resolve #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  if_idx,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic [2:0]        ex_cond,
  input  logic [DATA_W-1:0] ex_opnd,
  input  logic [IDX_W-1:0]  ex_idx,
  input  logic              ex_pred_taken,
  input  logic [DATA_W-1:0] ex_target,
  input  logic [DATA_W-1:0] ex_fallthru,
  output logic              flush,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mis_count,
  input  logic              stat_clr
);
  import branch_predict_resolve_pkg::*;

  localparam int              ENTRIES  = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(weak_nt_init(CNT_W));

  logic [CNT_W-1:0] bht [ENTRIES];
  logic             ex_taken;
  logic             res;
  logic             mispredict;

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
    .cond  (ex_cond),
    .opnd  (ex_opnd),
    .taken (ex_taken)
  );

  // The EX slot behind a flush is wrong-path and must be ignored.
  assign res        = ex_valid & ex_branch & ~flush;
  assign mispredict = ex_taken ^ ex_pred_taken;

  // No bypass: an update this cycle becomes visible next cycle.
  assign if_pred_taken = bht[if_idx][CNT_W-1];

  // Train the indexed counter toward the resolved outcome, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= CNT_INIT;
      end
    end else if (res) begin
      if (ex_taken) begin
        if (bht[ex_idx] != {CNT_W{1'b1}}) bht[ex_idx] <= bht[ex_idx] + CNT_W'(1);
      end else begin
        if (bht[ex_idx] != '0) bht[ex_idx] <= bht[ex_idx] - CNT_W'(1);
      end
    end
  end

  // One-cycle flush pulse with the corrected PC; redirect holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= res & mispredict;
      if (res & mispredict) redirect_pc <= ex_taken ? ex_target : ex_fallthru;
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_count  <= '0;
      mis_count <= '0;
    end else if (stat_clr) begin
      br_count  <= '0;
      mis_count <= '0;
    end else if (res) begin
      if (br_count != {STAT_W{1'b1}}) br_count <= br_count + STAT_W'(1);
      if (mispredict && (mis_count != {STAT_W{1'b1}})) mis_count <= mis_count + STAT_W'(1);
    end
  end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Parametrised successor to the single-bit branch condition logic.
- Adds a direct-mapped branch history table (BHT) of saturating counters for fetch-stage prediction.
- Adds a multi-condition resolver for the execute stage, plus a registered mispredict flush/redirect and saturating branch statistics.
- Sits between IF (lookup) and EX (resolve/update); drives pipeline flush and the PC redirect mux.

Parameters:
- DATA_W, 16, operand and PC width.
- IDX_W, 4, BHT index width; table has 2^IDX_W entries.
- CNT_W, 2, predictor counter width (>=1).
- STAT_W, 16, statistics counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_idx  in  IDX_W  BHT lookup index (low PC bits) from fetch.
- if_pred_taken  out  1  prediction for if_idx; combinational read of table registers.
- ex_valid  in  1  EX-stage instruction valid.
- ex_branch  in  1  EX instruction is a conditional/unconditional branch.
- ex_cond  in  3  condition code (see Behaviour).
- ex_opnd  in  DATA_W  Rs operand, signed two's complement.
- ex_idx  in  IDX_W  BHT index carried down the pipe from fetch.
- ex_pred_taken  in  1  prediction made at fetch for this branch.
- ex_target  in  DATA_W  taken target PC.
- ex_fallthru  in  DATA_W  PC+2.
- flush  out  1  one-cycle mispredict pulse.
- redirect_pc  out  DATA_W  correct PC, valid while flush=1.
- br_count  out  STAT_W  resolved branches.
- mis_count  out  STAT_W  mispredicts.
- stat_clr  in  1  synchronous clear of both stat counters.

Behaviour:
- Reset (rst=0, async): every BHT entry = 2^(CNT_W-1)-1 (weakly not-taken; 2'b01 for CNT_W=2); flush=0; redirect_pc=0; br_count=mis_count=0.
- Prediction: if_pred_taken = MSB of BHT[if_idx]. Zero-cycle lookup with no bypass: a same-cycle update to the same index is not visible until the next cycle.
- Condition codes (signed ex_opnd):
  - 000 EQZ
  - 001 NEZ
  - 010 LTZ
  - 011 GEZ
  - 100 GTZ (opnd>0)
  - 101 LEZ
  - 110 ALWAYS
  - 111 NEVER (reserved; resolves not-taken)
- Qualify: res = ex_valid & ex_branch & ~flush. The EX slot during a flush cycle is wrong-path and is ignored entirely: no update, no stats, no flush.
- On a rising edge with res=1:
  - taken = cond result.
  - BHT[ex_idx]: +1 if taken, saturating at 2^CNT_W-1; -1 if not taken, saturating at 0.
  - br_count += 1, saturating at all-ones.
  - If taken != ex_pred_taken: flush<=1, redirect_pc <= taken ? ex_target : ex_fallthru, and mis_count += 1 (saturating).
  - Otherwise flush<=0 and redirect_pc holds its value.
- Latency: flush/redirect assert exactly 1 cycle after the resolving EX cycle and last exactly 1 cycle. Back-to-back flushes are impossible by construction.
- res=0: flush<=0; BHT and stats unchanged.
- stat_clr=1 wins over an increment in the same cycle (both counters -> 0). It does not affect the BHT.
- Non-branch (ex_branch=0) or invalid: no effect regardless of other EX inputs.
- Reset asserted mid-operation: immediate async clear; a pending flush is dropped.
- Counters are never reloaded from the prediction; only resolved outcome trains them.

Decomposition:
- Shared package: condition-code localparams (COND_EQZ..COND_NEVER) and the weak-not-taken init constant function of CNT_W.
- One sub-module, branch_cond_eval: combinational (ex_cond, ex_opnd) -> taken. It is reused by any future compare-and-branch units.
- BHT and saturating counters stay in the top.

Test Plan:
- Reset then if_idx=3 -> if_pred_taken=0. Resolve two taken EQZ branches (opnd=0) at idx 3 with pred=0 -> BHT[3]=3, if_pred_taken=1. First resolve gives flush=1 next cycle, redirect_pc=ex_target=0x0040; second (pred=0 again) also flushes; mis_count=2.
- Saturation: four taken resolves at idx 5 -> counter 3 and stays 3. Five not-taken resolves -> counter 0 and stays 0.
- Condition sweep with pred=0, one opnd per code: opnd=0x8000 (-32768), 0x0000 and 0x0001 for EQZ..LEZ, plus ALWAYS/NEVER. Flush asserts exactly for the codes that evaluate taken (e.g. GTZ with 0x0001 flushes; GTZ with 0x0000 does not). NEVER never flushes when pred=0.
- Wrong-path squash: mispredict in cycle N; in cycle N+1 (flush=1) drive ex_valid=ex_branch=1 with a mispredict -> no flush in N+2, br_count increments only once, BHT untouched.
- Same-index collision: resolve idx 7 taken while if_idx=7 -> if_pred_taken shows the old value that cycle and the new value next cycle.
- Stats: STAT_W=4, 20 resolves -> br_count=15 (saturated). stat_clr with a concurrent resolve -> both counters 0 next cycle. Async rst pulse while flush=1 -> flush drops immediately and BHT returns to 2'b01.
